// File: rtl/vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pkg : shared VGA timing defaults, config field codes, colours, platform record
// Revision 1.0
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   // Platform fields are stored at a fixed width so the record type is
   // independent of the COORD_W chosen by each instance (COORD_W <= PLAT_W).
   localparam int PLAT_W = 16;

   localparam logic [2:0] BG_COLOR_DEF   = 3'b011;
   localparam logic [2:0] PLAT_COLOR_DEF = 3'b100;

   typedef enum logic [1:0] {
      FLD_PSTART = 2'd0,
      FLD_PEND   = 2'd1,
      FLD_HSTART = 2'd2,
      FLD_HEND   = 2'd3
   } cfg_field_e;

   typedef struct packed {
      logic [PLAT_W-1:0] pstart;
      logic [PLAT_W-1:0] pend;
      logic [PLAT_W-1:0] hstart;
      logic [PLAT_W-1:0] hend;
   } plat_t;

   // Half-open interval test; an interval with lo >= hi is empty.
   function automatic logic in_span(input logic [PLAT_W-1:0] v,
                                    input logic [PLAT_W-1:0] lo,
                                    input logic [PLAT_W-1:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing : pixel/line counters with combinational sync, active and frame flags
// Revision 1.0
// ---------------------------------------------------------------------------
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit SYNC_POL = 1'b0,
   parameter int COORD_W  = 10
) (
   input  logic               clk,
   input  logic               reset,
   output logic [COORD_W-1:0] hcnt,
   output logic [COORD_W-1:0] vcnt,
   output logic               hsync,
   output logic               vsync,
   output logic               active,
   output logic               frame_first,
   output logic               frame_last
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt <= hcnt + 1'b1;
      end
   end

   assign hsync       = ((hcnt >= HS_BEG) && (hcnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
   assign vsync       = ((vcnt >= VS_BEG) && (vcnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
   assign active      = (hcnt < H_VIS) && (vcnt < V_VIS);
   assign frame_first = (hcnt == '0) && (vcnt == '0);
   assign frame_last  = (hcnt == H_LAST) && (vcnt == V_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_scene_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_scene_gen : VGA timing plus platform/hole scene renderer, frame-synchronous config
// Revision 1.0
// ---------------------------------------------------------------------------
module vga_scene_gen
   import vga_pkg::*;
#(
   parameter int               H_ACTIVE   = H_ACTIVE_DEF,
   parameter int               H_FP       = H_FP_DEF,
   parameter int               H_SYNC     = H_SYNC_DEF,
   parameter int               H_BP       = H_BP_DEF,
   parameter int               V_ACTIVE   = V_ACTIVE_DEF,
   parameter int               V_FP       = V_FP_DEF,
   parameter int               V_SYNC     = V_SYNC_DEF,
   parameter int               V_BP       = V_BP_DEF,
   parameter bit               SYNC_POL   = 1'b0,
   parameter int               NUM_PLAT   = 4,
   parameter int               COORD_W    = 10,
   parameter int               RGB_W      = 3,
   parameter logic [RGB_W-1:0] BG_COLOR   = RGB_W'(BG_COLOR_DEF),
   parameter logic [RGB_W-1:0] PLAT_COLOR = RGB_W'(PLAT_COLOR_DEF)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [2:0]         cfg_idx,
   input  logic [1:0]         cfg_field,
   input  logic [COORD_W-1:0] cfg_data,
   output logic               hsync,
   output logic               vsync,
   output logic [RGB_W-1:0]   rgb,
   output logic               active,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               frame_start
);

   logic [COORD_W-1:0]  hcnt;
   logic [COORD_W-1:0]  vcnt;
   logic                t_hsync;
   logic                t_vsync;
   logic                t_active;
   logic                t_first;
   logic                t_last;
   logic [NUM_PLAT-1:0] paint;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_POL (SYNC_POL),
      .COORD_W  (COORD_W)
   ) u_timing (
      .clk         (clk),
      .reset       (reset),
      .hcnt        (hcnt),
      .vcnt        (vcnt),
      .hsync       (t_hsync),
      .vsync       (t_vsync),
      .active      (t_active),
      .frame_first (t_first),
      .frame_last  (t_last)
   );

   // Each platform owns a shadow bank (written any time) and a live bank
   // (copied on the last pixel of a frame) that alone feeds the renderer.
   for (genvar p = 0; p < NUM_PLAT; p++) begin : g_plat
      plat_t shadow;
      plat_t live;

      always_ff @(posedge clk) begin
         if (reset) begin
            shadow <= '0;
         end else if (cfg_we && (cfg_idx == 3'(p))) begin
            case (cfg_field_e'(cfg_field))
               FLD_PSTART: shadow.pstart <= PLAT_W'(cfg_data);
               FLD_PEND:   shadow.pend   <= PLAT_W'(cfg_data);
               FLD_HSTART: shadow.hstart <= PLAT_W'(cfg_data);
               FLD_HEND:   shadow.hend   <= PLAT_W'(cfg_data);
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            live <= '0;
         end else if (t_last) begin
            live <= shadow;
         end
      end

      assign paint[p] = in_span(PLAT_W'(vcnt), live.pstart, live.pend) &&
                        !in_span(PLAT_W'(hcnt), live.hstart, live.hend);
   end

   logic [NUM_PLAT-1:0] s2_paint;
   logic [COORD_W-1:0]  s2_x;
   logic [COORD_W-1:0]  s2_y;
   logic                s2_hsync;
   logic                s2_vsync;
   logic                s2_active;
   logic                s2_first;

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_paint  <= '0;
         s2_x      <= '0;
         s2_y      <= '0;
         s2_hsync  <= ~SYNC_POL;
         s2_vsync  <= ~SYNC_POL;
         s2_active <= 1'b0;
         s2_first  <= 1'b0;
      end else begin
         s2_paint  <= paint;
         s2_x      <= hcnt;
         s2_y      <= vcnt;
         s2_hsync  <= t_hsync;
         s2_vsync  <= t_vsync;
         s2_active <= t_active;
         s2_first  <= t_first;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb         <= '0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         active      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         rgb         <= !s2_active ? '0 : ((|s2_paint) ? PLAT_COLOR : BG_COLOR);
         pixel_x     <= s2_x;
         pixel_y     <= s2_y;
         hsync       <= s2_hsync;
         vsync       <= s2_vsync;
         active      <= s2_active;
         frame_start <= s2_first;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_scene_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_scene_gen : reduced-size scene instance and a wide-line SYNC_POL=1 instance
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_vga_scene_gen;

   localparam int AHA = 64, AHF = 4, AHS = 8, AHB = 4;
   localparam int AVA = 48, AVF = 2, AVS = 2, AVB = 3;
   localparam int AHT = AHA + AHF + AHS + AHB;
   localparam int AVT = AVA + AVF + AVS + AVB;
   localparam int AFT = AHT * AVT;
   localparam int BHA = 320, BHF = 8, BHS = 48, BHB = 24;
   localparam int BVA = 480, BVF = 10, BVS = 2, BVB = 33;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_idx = '0;
   logic [1:0] cfg_field = '0;
   logic [9:0] cfg_data = '0;

   logic       a_hsync, a_vsync, a_active, a_frame_start;
   logic [2:0] a_rgb;
   logic [9:0] a_pixel_x, a_pixel_y;
   logic       b_hsync, b_vsync, b_active, b_frame_start;
   logic [2:0] b_rgb;
   logic [9:0] b_pixel_x, b_pixel_y;

   vga_scene_gen #(
      .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
      .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB)
   ) dut_a (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_field(cfg_field), .cfg_data(cfg_data), .hsync(a_hsync), .vsync(a_vsync),
      .rgb(a_rgb), .active(a_active), .pixel_x(a_pixel_x), .pixel_y(a_pixel_y),
      .frame_start(a_frame_start)
   );

   vga_scene_gen #(
      .SYNC_POL(1'b1), .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB)
   ) dut_b (
      .clk(clk), .reset(reset), .cfg_we(1'b0), .cfg_idx(3'd0),
      .cfg_field(2'd0), .cfg_data(10'd0), .hsync(b_hsync), .vsync(b_vsync),
      .rgb(b_rgb), .active(b_active), .pixel_x(b_pixel_x), .pixel_y(b_pixel_y),
      .frame_start(b_frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      int at;
      int idx;
      int fld;
      int data;
   } wr_t;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       act;
      logic       fs;
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] rgb;
   } exp_t;

   wr_t wlog[$];
   int  e = 0;        // clock edges seen since reset was last released
   int  checks = 0;
   int  errors = 0;
   bit  started = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         e <= 0;
         wlog.delete();
      end else begin
         if (cfg_we)
            wlog.push_back('{e, int'(cfg_idx), int'(cfg_field), int'(cfg_data)});
         e <= e + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
      end
   endtask

   // Frame f shows the writes made strictly before its commit edge f*AFT-1.
   function automatic bit painted(input int f, input int x, input int y);
      int ps[4];
      int pe[4];
      int hs[4];
      int he[4];
      for (int p = 0; p < 4; p++) begin
         ps[p] = 0; pe[p] = 0; hs[p] = 0; he[p] = 0;
      end
      foreach (wlog[i]) begin
         if (wlog[i].at < f * AFT - 1 && wlog[i].idx < 4) begin
            case (wlog[i].fld)
               0: ps[wlog[i].idx] = wlog[i].data;
               1: pe[wlog[i].idx] = wlog[i].data;
               2: hs[wlog[i].idx] = wlog[i].data;
               default: he[wlog[i].idx] = wlog[i].data;
            endcase
         end
      end
      for (int p = 0; p < 4; p++)
         if (y >= ps[p] && y < pe[p] && !(x >= hs[p] && x < he[p]))
            return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t model(input int ee, input int ha, input int hf, input int hsw,
                                  input int hb, input int va, input int vf, input int vsw,
                                  input int vb, input bit pol, input bit use_cfg);
      exp_t m;
      int ht, vt, n, x, y, f;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      m = '0;
      m.hs = ~pol;
      m.vs = ~pol;
      if (ee < 2) return m;
      n = ee - 2;
      x = n % ht;
      y = (n / ht) % vt;
      f = n / (ht * vt);
      m.x   = 10'(x);
      m.y   = 10'(y);
      m.act = (x < ha) && (y < va);
      m.fs  = (x == 0) && (y == 0);
      m.hs  = (x >= ha + hf && x < ha + hf + hsw) ? pol : ~pol;
      m.vs  = (y >= va + vf && y < va + vf + vsw) ? pol : ~pol;
      if (m.act) m.rgb = (use_cfg && painted(f, x, y)) ? 3'b100 : 3'b011;
      return m;
   endfunction

   always @(negedge clk) begin
      exp_t ea;
      exp_t eb;
      if (started) begin
         ea = model(e, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, 1'b0, 1'b1);
         eb = model(e, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1'b1, 1'b0);
         chk("a_sync",  int'({a_hsync, a_vsync}),        int'({ea.hs, ea.vs}));
         chk("a_flags", int'({a_active, a_frame_start}), int'({ea.act, ea.fs}));
         chk("a_pos",   int'({a_pixel_y, a_pixel_x}),    int'({ea.y, ea.x}));
         chk("a_rgb",   int'(a_rgb),                     int'(ea.rgb));
         chk("b_sync",  int'({b_hsync, b_vsync}),        int'({eb.hs, eb.vs}));
         chk("b_flags", int'({b_active, b_frame_start}), int'({eb.act, eb.fs}));
         chk("b_pos",   int'({b_pixel_y, b_pixel_x}),    int'({eb.y, eb.x}));
         chk("b_rgb",   int'(b_rgb),                     int'(eb.rgb));
      end
   end

   task automatic wait_e(input int target);
      int guard;
      guard = 0;
      while (e < target && guard < 200000) begin
         @(negedge clk);
         guard++;
      end
      chk("wait_edge", e, target);
   endtask

   task automatic at_pix(input int f, input int x, input int y);
      wait_e(f * AFT + y * AHT + x + 2);
   endtask

   task automatic cfg_write(input int idx, input int fld, input int data);
      cfg_we    = 1'b1;
      cfg_idx   = 3'(idx);
      cfg_field = 2'(fld);
      cfg_data  = 10'(data);
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   initial begin
      repeat (4) @(negedge clk);
      started = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("lit_fs_early", int'(a_frame_start), 0);
      @(negedge clk);
      chk("lit_first_fs", int'(a_frame_start), 1);
      chk("lit_first_x",  int'(a_pixel_x), 0);
      chk("lit_first_y",  int'(a_pixel_y), 0);

      wait_e(69);
      chk("lit_a_hs_before", int'(a_hsync), 1);
      wait_e(70);
      chk("lit_a_hs_fall", int'(a_hsync), 0);
      chk("lit_a_hs_fall_x", int'(a_pixel_x), 68);
      wait_e(329);
      chk("lit_b_hs_327", int'(b_hsync), 0);
      wait_e(330);
      chk("lit_b_hs_328", int'(b_hsync), 1);
      wait_e(377);
      chk("lit_b_hs_375", int'(b_hsync), 1);
      wait_e(378);
      chk("lit_b_hs_376", int'(b_hsync), 0);
      wait_e(402);
      chk("lit_b_period_x", int'(b_pixel_x), 0);
      chk("lit_b_period_y", int'(b_pixel_y), 1);

      // Mid-frame write: invisible until the next frame.
      wait_e(1000);
      cfg_write(0, 0, 40);
      cfg_write(0, 1, 42);
      cfg_write(0, 2, 10);
      cfg_write(0, 3, 15);
      at_pix(0, 9, 41);   chk("lit_f0_unchanged", int'(a_rgb), 3'b011);
      at_pix(1, 9, 40);   chk("lit_f1_y40_x9",    int'(a_rgb), 3'b100);
      at_pix(1, 9, 41);   chk("lit_f1_x9",        int'(a_rgb), 3'b100);
      at_pix(1, 10, 41);  chk("lit_f1_x10_hole",  int'(a_rgb), 3'b011);
      at_pix(1, 14, 41);  chk("lit_f1_x14_hole",  int'(a_rgb), 3'b011);
      at_pix(1, 15, 41);  chk("lit_f1_x15",       int'(a_rgb), 3'b100);
      at_pix(1, 9, 42);   chk("lit_f1_y42",       int'(a_rgb), 3'b011);

      // Write landing on the commit edge is deferred by one more frame.
      cfg_write(2, 1, 30);
      wait_e(2 * AFT - 1);
      cfg_write(2, 0, 20);
      at_pix(2, 5, 10);   chk("lit_f2_commit_old", int'(a_rgb), 3'b100);
      at_pix(3, 5, 10);   chk("lit_f3_commit_new", int'(a_rgb), 3'b011);
      at_pix(3, 5, 25);   chk("lit_f3_plat2",      int'(a_rgb), 3'b100);

      // Overlapping platforms plus an out-of-range index.
      cfg_write(0, 0, 30); cfg_write(0, 1, 36); cfg_write(0, 2, 0);  cfg_write(0, 3, 0);
      cfg_write(1, 0, 33); cfg_write(1, 1, 39); cfg_write(1, 2, 20); cfg_write(1, 3, 26);
      cfg_write(5, 3, 0);  cfg_write(5, 0, 1);
      at_pix(4, 22, 34);  chk("lit_f4_overlap",  int'(a_rgb), 3'b100);
      at_pix(4, 19, 37);  chk("lit_f4_p1_solid", int'(a_rgb), 3'b100);
      at_pix(4, 22, 37);  chk("lit_f4_p1_hole",  int'(a_rgb), 3'b011);

      repeat (8000) begin
         @(negedge clk);
         if ($urandom_range(39) == 0) begin
            cfg_we    = 1'b1;
            cfg_idx   = 3'($urandom_range(7));
            cfg_field = 2'($urandom_range(3));
            cfg_data  = 10'($urandom_range(AHT - 1));
         end else begin
            cfg_we = 1'b0;
         end
      end
      @(negedge clk);
      cfg_we = 1'b0;

      // Mid-frame reset: restart at (0,0), configuration discarded.
      repeat (1234) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("lit_rst_fs", int'(a_frame_start), 1);
      at_pix(1, 22, 34);  chk("lit_rst_cleared", int'(a_rgb), 3'b011);
      wait_e(AFT + 3000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_scene_gen.md
Name: vga_scene_gen

Overview:
- Parametrised VGA timing and scene renderer.
- Generates hsync/vsync from configurable porch/sync/active widths.
- Paints NUM_PLAT horizontal platforms, each with one hole, over a background colour. Platform geometry is written through a register port and applied only at frame boundaries, so no frame is ever torn.
- Sits between game logic (platform writer) and the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, sync pulse level (0 = active-low)
- NUM_PLAT, 4, number of platforms (1..8)
- COORD_W, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- RGB_W, 3, colour width
- BG_COLOR, 3'b011, background and hole colour
- PLAT_COLOR, 3'b100, platform colour

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- cfg_we  in  1  write strobe, one write per cycle
- cfg_idx  in  3  platform index
- cfg_field  in  2  0=plat_start(y), 1=plat_end(y), 2=hole_start(x), 3=hole_end(x)
- cfg_data  in  COORD_W  field value
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- rgb  out  RGB_W  pixel colour
- active  out  1  visible-region flag
- pixel_x  out  COORD_W  x of the pixel currently presented on rgb
- pixel_y  out  COORD_W  y of the pixel currently presented on rgb
- frame_start  out  1  one-cycle pulse when pixel (0,0) is presented

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Counters: hcnt counts 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and vcnt increments; vcnt wraps 0 after V_TOTAL-1.
- Sync: hsync is asserted (= SYNC_POL) for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. [656,752); vsync likewise on vcnt, i.e. [490,492).
- Pipeline: stage 1 = counters; stage 2 = per-platform range compares (registered); stage 3 = colour select (registered).
- Alignment: hsync, vsync, rgb, active, pixel_x, pixel_y and frame_start are registered outputs, all delayed to match. Every output reflects counter value (hcnt,vcnt) exactly 2 cycles after the counters held it.
- Colour:
  - rgb = 0 when not active.
  - Otherwise rgb = PLAT_COLOR if any platform p has plat_start[p] <= y < plat_end[p] and not (hole_start[p] <= x < hole_end[p]); else BG_COLOR.
  - A platform with plat_start >= plat_end is disabled. An empty hole (hole_start >= hole_end) means a solid platform.
  - Overlapping platforms: PLAT_COLOR if any platform paints the pixel (OR). A hole in one platform does not cut another.
- Config, double-buffered:
  - cfg_we writes cfg_data to shadow[cfg_idx][cfg_field] at the clock edge.
  - cfg_idx >= NUM_PLAT: write ignored.
  - Shadow copies to the active set on the cycle when hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1.
  - A write on that same cycle lands in shadow only and is committed at the next frame end.
  - The render path reads only the active set.
- Reset:
  - hcnt = vcnt = 0.
  - All shadow and active fields = 0, so all platforms are disabled.
  - Pipeline registers cleared: rgb = 0, active = 0, pixel_x = pixel_y = 0, frame_start = 0, hsync = vsync = ~SYNC_POL (deasserted).
  - Reset mid-frame restarts at (0,0) the next cycle. Pending shadow writes are lost.
  - The first frame_start pulse comes 2 cycles after reset deasserts.

Decomposition:
- Shared package vga_pkg:
  - Default timing constants for 640x480@60.
  - cfg_field encodings (FLD_PSTART, FLD_PEND, FLD_HSTART, FLD_HEND).
  - Colour constants.
  - Plat_t struct {pstart, pend, hstart, hend}.
- Sub-module vga_timing: counters, sync generation and active flag, with the same timing parameters.
- vga_scene_gen instantiates vga_timing and holds the config banks and render pipeline.

Test Plan:
- Reset, then run 2 frames with default parameters -> hsync low for 96 cycles every 800; vsync low on lines 490-491; frame_start every 420000 cycles; rgb = 3'b011 for all active pixels; rgb = 0 at x >= 640 or y >= 480.
- Write platform 0 = {400, 420, 100, 150} mid-frame -> unchanged scene until the next frame_start. Then at y=410: x=99 gives 3'b100, x=100..149 give 3'b011, x=150 gives 3'b100. y=420 gives 3'b011.
- Write on the commit cycle (hcnt=799, vcnt=524) -> value is not visible in the following frame; visible one frame later.
- Platforms 0 {100,110,0,0} and 1 {105,115,50,60}, and cfg_idx=5 write -> y=107 x=55 gives 3'b100 (platform 0 covers the hole); y=112 x=55 gives 3'b011; the idx-5 write has no effect.
- Latency check -> first frame_start 2 cycles after reset release with pixel_x=0, pixel_y=0. The hsync falling edge coincides with pixel_x=656.
- Parameter override SYNC_POL=1, H_ACTIVE=320, H_FP=8, H_SYNC=48, H_BP=24 -> hsync high for hcnt 328..375; line period 400.
